// File: rtl/lsu_mmio_pipe_if.sv
// -----------------------------------------------------------------------------
// lsu_mmio_pipe_if
// Request/response bus between the MEM stage of the core and the LSU.
//   i_req / i_lsu_wren / i_type_access / i_lsu_addr / i_st_data : request side
//   o_ready / o_valid / o_ld_data / o_fault                     : response side
// Modports:
//   master : the core pipeline (drives the request, observes the response)
//   slave  : the LSU (observes the request, drives the response)
// -----------------------------------------------------------------------------
interface lsu_mmio_pipe_if;
    logic        i_req;
    logic        i_lsu_wren;
    logic [2:0]  i_type_access;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_ld_data;
    logic        o_fault;

    modport master (
        output i_req, i_lsu_wren, i_type_access, i_lsu_addr, i_st_data,
        input  o_ready, o_valid, o_ld_data, o_fault
    );

    modport slave (
        input  i_req, i_lsu_wren, i_type_access, i_lsu_addr, i_st_data,
        output o_ready, o_valid, o_ld_data, o_fault
    );
endinterface

// File: rtl/lsu_mmio_pipe.sv
// -----------------------------------------------------------------------------
// lsu_mmio_pipe
// RV32I load/store unit for the MEM stage. Accepts one access per handshake,
// serves it from the internal data memory or the MMIO registers (LEDR, LEDG,
// HEX, LCD, switches), and returns a one-cycle o_valid pulse per access.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   bus (slave)      request/response handshake, see lsu_mmio_pipe_if
//   i_io_sw          switch inputs, read-only at 0x1001_0xxx
//   o_io_ledr/ledg   LED registers
//   o_io_hex         seven-segment digits, digit k at [7k+6:7k]
//   o_io_lcd         LCD register
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned H/W
// accesses instead of silently forcing natural alignment.
// -----------------------------------------------------------------------------
module lsu_mmio_pipe #(
    parameter int DMEM_WORDS  = 2048,
    parameter int MEM_LATENCY = 2,
    parameter int NUM_HEX     = 8,
    parameter int LEDR_W      = 17,
    parameter int LEDG_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    lsu_mmio_pipe_if.slave       bus,
    input  logic [31:0]          i_io_sw,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd
);
    localparam int          AW        = $clog2(DMEM_WORDS);
    // WAIT holds for MEM_LATENCY-1 cycles: the counter runs from N-2 down to 0.
    localparam logic [3:0]  WAIT_INIT = 4'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);
    localparam logic [19:0] PG_LEDR   = 20'h10000;
    localparam logic [19:0] PG_LEDG   = 20'h10001;
    localparam logic [19:0] PG_HEX0   = 20'h10002;
    localparam logic [19:0] PG_HEX1   = 20'h10003;
    localparam logic [19:0] PG_LCD    = 20'h10004;
    localparam logic [19:0] PG_SW     = 20'h10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] size);
        case (size)
            2'b01:   return {a[31:1], 1'b0};
            2'b10:   return {a[31:2], 2'b00};
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data onto every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, valid_q, fault_q;
    logic [31:0]       ld_data_q;
    logic [LEDR_W-1:0] ledr_q;
    logic [LEDG_W-1:0] ledg_q;
    logic [6:0]        hex_q [8];
    logic [31:0]       lcd_q;
    logic [31:0]       mem_q [DMEM_WORDS];

    logic              accept_s, illegal_s, fault_s, is_dmem_s, dmem_wr_s, io_wr_s;
    logic [1:0]        size_s;
    logic [31:0]       addr_s, wdata_s, rword_s, ld_ext_s, hex_lo_s, hex_hi_s;
    logic [19:0]       page_s;
    logic [3:0]        be_s;
    logic [AW-1:0]     widx_s;

    // Request decode: fault, effective address, region, lanes
    always_comb begin
        size_s    = bus.i_type_access[1:0];
        illegal_s = (bus.i_type_access == 3'b011) || (bus.i_type_access[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        fault_s   = illegal_s ||
                    ((size_s == 2'b01) && bus.i_lsu_addr[0]) ||
                    ((size_s == 2'b10) && (bus.i_lsu_addr[1:0] != 2'b00));
        addr_s    = bus.i_lsu_addr;
`else
        fault_s   = illegal_s;
        addr_s    = align_addr(bus.i_lsu_addr, size_s);
`endif
        accept_s  = bus.i_req && ready_q && !i_reset;
        page_s    = addr_s[31:12];
        is_dmem_s = ({2'b00, addr_s[31:2]} < 32'(DMEM_WORDS));
        widx_s    = addr_s[AW+1:2];
        be_s      = byte_en(size_s, addr_s[1:0]);
        wdata_s   = store_lanes(size_s, bus.i_st_data);
        dmem_wr_s = accept_s && bus.i_lsu_wren && !fault_s && is_dmem_s;
        io_wr_s   = accept_s && bus.i_lsu_wren && !fault_s && !is_dmem_s;
    end

    // Pack stored digits into the HEX register readback words
    always_comb begin
        hex_lo_s = 32'h0000_0000;
        hex_hi_s = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            hex_lo_s[8*k +: 8] = {1'b0, hex_q[k]};
            hex_hi_s[8*k +: 8] = {1'b0, hex_q[k+4]};
        end
    end

    // Read word selection and load extension
    always_comb begin
        rword_s = 32'h0000_0000;
        if (is_dmem_s) begin
            rword_s = mem_q[widx_s];
        end else begin
            case (page_s)
                PG_LEDR: rword_s = 32'(ledr_q);
                PG_LEDG: rword_s = 32'(ledg_q);
                PG_HEX0: rword_s = hex_lo_s;
                PG_HEX1: rword_s = hex_hi_s;
                PG_LCD:  rword_s = lcd_q;
                PG_SW:   rword_s = i_io_sw;
                default: rword_s = 32'h0000_0000;
            endcase
        end
        ld_ext_s = load_extend(rword_s, addr_s[1:0], bus.i_type_access);
    end

    // FSM next state: only non-faulted DMEM loads pass through WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (!bus.i_lsu_wren && !fault_s && is_dmem_s && (MEM_LATENCY > 1)) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state register with registered ready/valid decode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != ST_WAIT);
            valid_q <= (state_d == ST_RESP);
        end
    end

    // Response capture at accept; held through WAIT until the RESP cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fault_q   <= 1'b0;
            ld_data_q <= 32'h0000_0000;
        end else if (accept_s) begin
            fault_q   <= fault_s;
            ld_data_q <= (bus.i_lsu_wren || fault_s) ? 32'h0000_0000 : ld_ext_s;
        end
    end

    // Data memory byte-lane write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (dmem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // MMIO register writes; the switch page and unmapped pages drop stores
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= 32'h0000_0000;
            for (int k = 0; k < 8; k++) begin
                hex_q[k] <= 7'h00;
            end
        end else if (io_wr_s) begin
            case (page_s)
                PG_LEDR: ledr_q <= LEDR_W'(merge_bytes(32'(ledr_q), wdata_s, be_s));
                PG_LEDG: ledg_q <= LEDG_W'(merge_bytes(32'(ledg_q), wdata_s, be_s));
                PG_LCD:  lcd_q  <= merge_bytes(lcd_q, wdata_s, be_s);
                PG_HEX0: begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_s[k] && (k < NUM_HEX)) hex_q[k] <= wdata_s[8*k +: 7];
                    end
                end
                PG_HEX1: begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_s[k] && (k + 4 < NUM_HEX)) hex_q[k+4] <= wdata_s[8*k +: 7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the implemented digits onto the HEX output bus
    always_comb begin
        o_io_hex = {(7*NUM_HEX){1'b0}};
        for (int k = 0; k < NUM_HEX; k++) begin
            o_io_hex[7*k +: 7] = hex_q[k];
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_fault   = fault_q;
    assign bus.o_ld_data = ld_data_q;
    assign o_io_ledr     = ledr_q;
    assign o_io_ledg     = ledg_q;
    assign o_io_lcd      = lcd_q;
endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// -----------------------------------------------------------------------------
// tb_lsu_mmio_pipe
// Directed and random accesses against a byte-level reference model of the
// data memory and MMIO map. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_lsu_mmio_pipe;
    localparam int DMEM_WORDS  = 2048;
    localparam int MEM_LATENCY = 2;
    localparam int NUM_HEX     = 8;
    localparam int LEDR_W      = 17;
    localparam int LEDG_W      = 8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          io_sw;
    logic [LEDR_W-1:0]    ledr;
    logic [LEDG_W-1:0]    ledg;
    logic [7*NUM_HEX-1:0] hex;
    logic [31:0]          lcd;

    lsu_mmio_pipe_if bus ();

    lsu_mmio_pipe #(
        .DMEM_WORDS(DMEM_WORDS), .MEM_LATENCY(MEM_LATENCY), .NUM_HEX(NUM_HEX),
        .LEDR_W(LEDR_W), .LEDG_W(LEDG_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus), .i_io_sw(io_sw),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_mem [DMEM_WORDS*4];
    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [6:0]  m_hex [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset_io();
        m_ledr = 32'h0; m_ledg = 32'h0; m_lcd = 32'h0;
        for (int k = 0; k < 8; k++) m_hex[k] = 7'h0;
    endtask

    function automatic logic [31:0] m_io_read(input logic [19:0] page);
        logic [31:0] w;
        w = 32'h0;
        case (page)
            20'h10000: w = m_ledr;
            20'h10001: w = m_ledg;
            20'h10002: for (int b = 0; b < 4; b++) w[8*b +: 8] = {1'b0, m_hex[b]};
            20'h10003: for (int b = 0; b < 4; b++) w[8*b +: 8] = {1'b0, m_hex[b+4]};
            20'h10004: w = m_lcd;
            20'h10010: w = io_sw;
            default:   w = 32'h0;
        endcase
        return w;
    endfunction

    task automatic m_io_write(input logic [19:0] page, input logic [31:0] w);
        case (page)
            20'h10000: m_ledr = w & 32'((64'd1 << LEDR_W) - 64'd1);
            20'h10001: m_ledg = w & 32'((64'd1 << LEDG_W) - 64'd1);
            20'h10002: for (int b = 0; b < 4; b++) if (b < NUM_HEX) m_hex[b] = w[8*b +: 7];
            20'h10003: for (int b = 0; b < 4; b++) if (b + 4 < NUM_HEX) m_hex[b+4] = w[8*b +: 7];
            20'h10004: m_lcd = w;
            default: ;
        endcase
    endtask

    function automatic logic [7*NUM_HEX-1:0] m_hex_vec();
        logic [7*NUM_HEX-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_HEX; k++) v[7*k +: 7] = m_hex[k];
        return v;
    endfunction

    // Applies one access to the model and returns the expected response.
    task automatic model_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] e_d,
                                output logic e_f, output int e_lat);
        int unsigned size, ea;
        logic [31:0] v, w;
        bit illegal, misal, dm;
        e_d = 32'h0; e_f = 1'b0; e_lat = 1;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (illegal) begin e_f = 1'b1; return; end
        size  = 1 << f3[1:0];
        misal = (addr % size) != 0;
        if (TRAP && misal) begin e_f = 1'b1; return; end
        ea = addr - (addr % size);
        dm = ea < DMEM_WORDS * 4;
        w  = dm ? 32'h0 : m_io_read(20'(ea >> 12));
        if (wr) begin
            for (int i = 0; i < int'(size); i++) begin
                int unsigned ba = ea + i;
                if (dm) m_mem[ba] = 8'(data >> (8 * i));
                else    w[8*(ba%4) +: 8] = 8'(data >> (8 * i));
            end
            if (!dm) m_io_write(20'(ea >> 12), w);
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(size); i++) begin
                int unsigned ba = ea + i;
                logic [7:0] by;
                by = dm ? m_mem[ba] : w[8*(ba%4) +: 8];
                v = v | (32'(by) << (8 * i));
            end
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            e_d   = v;
            e_lat = dm ? MEM_LATENCY : 1;
        end
    endtask

    task automatic check_io(input string tag);
        chk({tag, ":ledr"}, 64'(ledr), 64'(m_ledr));
        chk({tag, ":ledg"}, 64'(ledg), 64'(m_ledg));
        chk({tag, ":hex"},  64'(hex),  64'(m_hex_vec()));
        chk({tag, ":lcd"},  64'(lcd),  64'(m_lcd));
    endtask

    // One access: called just after a falling edge, returns just after the
    // falling edge where o_valid is seen (so the next call is back-to-back).
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input string tag, output logic [31:0] obs);
        logic [31:0] e_d;
        logic e_f;
        int e_lat, lat, wait_n;
        bit ready_seen;
        bus.i_req = 1'b1; bus.i_lsu_wren = wr; bus.i_type_access = f3;
        bus.i_lsu_addr = addr; bus.i_st_data = data;
        wait_n = 0;
        while (bus.o_ready !== 1'b1 && wait_n < 40) begin @(negedge clk); wait_n++; end
        chk({tag, ":ready"}, 64'(bus.o_ready), 64'd1);
        @(posedge clk);
        model_access(wr, f3, addr, data, e_d, e_f, e_lat);
        @(negedge clk);
        lat = 1;
        ready_seen = 1'b0;
        while (bus.o_valid !== 1'b1 && lat < 40) begin
            if (bus.o_ready !== 1'b0) ready_seen = 1'b1;
            // Junk request while waiting: must be ignored.
            bus.i_req = 1'b1; bus.i_lsu_wren = 1'b1; bus.i_type_access = 3'b010;
            bus.i_lsu_addr = 32'($urandom_range(0, 63)); bus.i_st_data = $urandom;
            @(negedge clk);
            lat++;
        end
        bus.i_req = 1'b0;
        chk({tag, ":valid"}, 64'(bus.o_valid), 64'd1);
        chk({tag, ":lat"},   64'(lat),         64'(e_lat));
        chk({tag, ":fault"}, 64'(bus.o_fault), 64'(e_f));
        chk({tag, ":data"},  64'(bus.o_ld_data), 64'(e_d));
        if (e_lat > 1) chk({tag, ":ready_in_wait"}, 64'(ready_seen), 64'd0);
        obs = bus.o_ld_data;
        check_io(tag);
    endtask

    initial begin
        logic [31:0] obs, a, d;
        logic [2:0]  f3;
        bit          vseen;
        logic [19:0] pages [6];
        logic [2:0]  legal [5];
        logic [2:0]  bad [3];
        pages = '{20'h10000, 20'h10001, 20'h10002, 20'h10003, 20'h10004, 20'h10010};
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad   = '{3'b011, 3'b110, 3'b111};

        rst = 1'b1; io_sw = 32'h0;
        bus.i_req = 1'b0; bus.i_lsu_wren = 1'b0; bus.i_type_access = 3'b000;
        bus.i_lsu_addr = 32'h0; bus.i_st_data = 32'h0;
        m_reset_io();
        repeat (3) @(negedge clk);
        chk("rst:valid", 64'(bus.o_valid), 64'd0);
        chk("rst:fault", 64'(bus.o_fault), 64'd0);
        chk("rst:ld",    64'(bus.o_ld_data), 64'd0);
        chk("rst:ready", 64'(bus.o_ready), 64'd1);
        check_io("rst");
        rst = 1'b0;
        @(negedge clk);

        // Give the exercised DMEM window known contents.
        for (int i = 0; i < 16; i++) access(1'b1, 3'b010, 32'(i * 4), $urandom, "init", obs);

        // Word store then load
        access(1'b1, 3'b010, 32'h4, 32'hABCD1234, "t1_sw", obs);
        access(1'b0, 3'b010, 32'h4, 32'h0, "t1_lw", obs);
        chk("t1_value", 64'(obs), 64'h0000_0000_ABCD_1234);

        // Byte store, signed/unsigned byte loads, word readback
        access(1'b1, 3'b000, 32'h15, 32'hFFFFFF80, "t2_sb", obs);
        access(1'b0, 3'b000, 32'h15, 32'h0, "t2_lb", obs);
        chk("t2_lb_value", 64'(obs), 64'h0000_0000_FFFF_FF80);
        access(1'b0, 3'b100, 32'h15, 32'h0, "t2_lbu", obs);
        chk("t2_lbu_value", 64'(obs), 64'h0000_0000_0000_0080);
        access(1'b0, 3'b010, 32'h14, 32'h0, "t2_lw", obs);
        chk("t2_lw_byte1", 64'(obs[15:8]), 64'h80);

        // HEX digits
        access(1'b1, 3'b010, 32'h1000_2000, 32'hCAFEBABE, "t3_hex0", obs);
        chk("t3_digits", 64'(hex[27:0]), 64'({7'h4A, 7'h7E, 7'h3A, 7'h3E}));
        access(1'b1, 3'b000, 32'h1000_3001, 32'h0000_0001, "t3_hex5", obs);
        chk("t3_digit5", 64'(hex[41:35]), 64'h01);

        // Switches: read in one cycle, stores dropped
        io_sw = 32'h1111_2222;
        access(1'b0, 3'b010, 32'h1001_0000, 32'h0, "t4_lw_sw", obs);
        chk("t4_sw_value", 64'(obs), 64'h0000_0000_1111_2222);
        access(1'b1, 3'b010, 32'h1001_0000, 32'h5555_AAAA, "t4_sw_sw", obs);

        // Illegal funct3: fault, no side effect
        access(1'b1, 3'b111, 32'h8, 32'hDEAD_0000, "ill_st", obs);
        access(1'b0, 3'b011, 32'h8, 32'h0, "ill_ld", obs);
        access(1'b0, 3'b010, 32'h8, 32'h0, "ill_chk", obs);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 3'b001, 32'h3, 32'h0, "t6_lh_mis", obs);
        chk("t6_lh_zero", 64'(obs), 64'd0);
        access(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, "t6_sw_mis", obs);
        access(1'b0, 3'b010, 32'h4, 32'h0, "t6_lw", obs);
        chk("t6_untouched", 64'(obs), 64'h0000_0000_ABCD_1234);
`else
        access(1'b1, 3'b010, 32'h6, 32'hDEADBEEF, "t6_sw_mis", obs);
        access(1'b0, 3'b010, 32'h4, 32'h0, "t6_lw", obs);
        chk("t6_aligned", 64'(obs), 64'h0000_0000_DEAD_BEEF);
`endif

        // Back-to-back store/load, then reset in the middle of a load
        access(1'b1, 3'b010, 32'h20, 32'h5A5A_0F0F, "t5_sw", obs);
        access(1'b0, 3'b010, 32'h20, 32'h0, "t5_lw", obs);
        chk("t5_b2b", 64'(obs), 64'h0000_0000_5A5A_0F0F);
        bus.i_req = 1'b1; bus.i_lsu_wren = 1'b0; bus.i_type_access = 3'b010;
        bus.i_lsu_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("t5_wait_ready", 64'(bus.o_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vseen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.o_valid !== 1'b0) vseen = 1'b1;
            @(negedge clk);
        end
        chk("t5_no_valid", 64'(vseen), 64'd0);
        m_reset_io();
        check_io("t5_reset");
        access(1'b0, 3'b010, 32'h20, 32'h0, "t5_kept", obs);
        chk("t5_dmem_kept", 64'(obs), 64'h0000_0000_5A5A_0F0F);

        // Random mix across DMEM, MMIO and unmapped space
        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 63));
            else if (r < 9) a = {pages[$urandom_range(0, 5)], 12'($urandom_range(0, 7))};
            else            a = ($urandom_range(0, 1) == 0) ? 32'h0000_2000 : 32'h2000_0004;
            f3 = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : legal[$urandom_range(0, 4)];
            d = $urandom;
            io_sw = $urandom;
            access(1'($urandom_range(0, 1)), f3, a, d, "rnd", obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
